pwm_capture: RTL and testbench

- Receive-side counterpart of the board's servo PWM generator: measures the high time and period of an incoming PWM waveform in clk cycles.
- Feeds the measured duty cycle to loopback self-test, status displays, or a servo-position readback path.
- Sits on the 50 MHz board clock, with the pwm_in pin taken directly from I/O, so it is asynchronous.
- Flags loss of signal (stuck high or stuck low) with a timeout.

---
 rtl/pwm_capture.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_capture.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an async PWM input; PWM_CAPTURE_FILTER_EN adds a glitch filter.
// Latency: input rise to meas_valid is 4 clk (4+FILT_CYCLES with the filter).
// Backpressure: none; a free-running measurement with a one-cycle meas_valid pulse.
module pwm_capture #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int FILT_CYCLES    = 4
) (
    input  logic             clk,
    input  logic             rst_s_p,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((TIMEOUT_CYCLES < 1) || (FILT_CYCLES < 1) ||
        ((CNT_W < 31) && (TIMEOUT_CYCLES >= (1 << CNT_W)))) begin : g_param_check
        $error("pwm_capture: illegal parameter set");
    end

    logic             sync_1, sync_2, lvl, lvl_q, lvl_qq;
    logic             rise_det, fall_det;
    state_t           state, state_n;
    logic [CNT_W-1:0] per_cnt, per_n, per_inc;
    logic [CNT_W-1:0] hi_cnt, hi_n, hi_inc;
    logic [CNT_W-1:0] hi_lat, hi_lat_n;
    logic [CNT_W-1:0] idle_cnt, idle_n;
    logic             meas_n, to_hit;
    logic             upd_vld;
    logic [CNT_W-1:0] upd_per, upd_hi;

    always_ff @(posedge clk) begin
        if (rst_s_p) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILT_CYCLES + 1);

    logic [FW-1:0] filt_cnt;
    logic          filt_lvl;

    // Level flips only after FILT_CYCLES consecutive disagreeing samples, so both edges see the same delay.
    always_ff @(posedge clk) begin
        if (rst_s_p) begin
            filt_lvl <= 1'b0;
            filt_cnt <= '0;
        end else if (sync_2 != filt_lvl) begin
            if (filt_cnt == FW'(FILT_CYCLES - 1)) begin
                filt_lvl <= sync_2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync_2;
`endif

    always_ff @(posedge clk) begin
        if (rst_s_p) begin
            lvl_q  <= 1'b0;
            lvl_qq <= 1'b0;
        end else begin
            lvl_q  <= lvl;
            lvl_qq <= lvl_q;
        end
    end

    assign rise_det = lvl_q & ~lvl_qq;
    assign fall_det = ~lvl_q & lvl_qq;
    assign per_inc  = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
    assign hi_inc   = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_ONE;

    always_comb begin
        state_n  = state;
        per_n    = per_cnt;
        hi_n     = hi_cnt;
        hi_lat_n = hi_lat;
        idle_n   = idle_cnt;
        meas_n   = 1'b0;
        to_hit   = 1'b0;
        case (state)
            IDLE: begin
                per_n = '0;
                hi_n  = '0;
                if (rise_det) begin
                    state_n = HIGH;
                    per_n   = CNT_ONE;
                    hi_n    = CNT_ONE;
                    idle_n  = '0;
                end else if (fall_det) begin
                    idle_n = '0;
                end else if (idle_cnt != TO_LIM) begin
                    idle_n = idle_cnt + CNT_ONE;
                    to_hit = (idle_n == TO_LIM);
                end
            end
            HIGH: begin
                if (per_cnt == TO_LIM) begin
                    to_hit  = 1'b1;
                    state_n = IDLE;
                    per_n   = '0;
                    hi_n    = '0;
                    idle_n  = '0;
                end else begin
                    per_n = per_inc;
                    hi_n  = hi_inc;
                    if (fall_det) begin
                        state_n  = LOW;
                        hi_lat_n = hi_cnt;
                    end
                end
            end
            LOW: begin
                // A rise on the timeout cycle still closes the period.
                if (rise_det) begin
                    meas_n  = 1'b1;
                    state_n = HIGH;
                    per_n   = CNT_ONE;
                    hi_n    = CNT_ONE;
                end else if (per_cnt == TO_LIM) begin
                    to_hit  = 1'b1;
                    state_n = IDLE;
                    per_n   = '0;
                    hi_n    = '0;
                    idle_n  = '0;
                end else begin
                    per_n = per_inc;
                end
            end
            default: begin
                state_n = IDLE;
                per_n   = '0;
                hi_n    = '0;
                idle_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_s_p) begin
            state    <= IDLE;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            hi_lat   <= '0;
            idle_cnt <= '0;
            upd_vld  <= 1'b0;
            upd_per  <= '0;
            upd_hi   <= '0;
        end else begin
            state    <= state_n;
            per_cnt  <= per_n;
            hi_cnt   <= hi_n;
            hi_lat   <= hi_lat_n;
            idle_cnt <= idle_n;
            upd_vld  <= meas_n;
            if (meas_n) begin
                upd_per <= per_cnt;
                upd_hi  <= hi_lat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_s_p) begin
            high_count   <= '0;
            period_count <= '0;
            meas_valid   <= 1'b0;
            timeout      <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            meas_valid <= upd_vld;
            if (upd_vld) begin
                high_count   <= upd_hi;
                period_count <= upd_per;
                timeout      <= 1'b0;
            end
            if (to_hit) begin
                timeout     <= 1'b1;
                stuck_level <= lvl_q;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and random PWM waveforms checked every cycle against a timing model.
module tb_pwm_capture;

    localparam int CNT_W = 32;
    localparam int T     = 500;
    localparam int FC    = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    // The model's filtered stream flips FC-1 samples after the raw change, hence one extra cycle here.
    localparam int LAT_M = FILT ? 5 : 4;

    logic             clk;
    logic             rst_s_p;
    logic             pwm_in;
    logic [CNT_W-1:0] high_count, period_count;
    logic             meas_valid, timeout, stuck_level;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(T), .FILT_CYCLES(FC)) dut (
        .clk         (clk),
        .rst_s_p     (rst_s_p),
        .pwm_in      (pwm_in),
        .high_count  (high_count),
        .period_count(period_count),
        .meas_valid  (meas_valid),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit is_to;
        int p;
        int h;
        bit lvl;
    } ev_t;

    ev_t evq[$];
    bit  hist[$];
    int  cyc = 0;
    int  last_rise = 0, last_fall = 0;
    bit  armed = 0, prev = 0, flvl = 0;
    bit  exp_mv = 0, exp_to = 0, exp_sl = 0;
    int  exp_hc = 0, exp_pc = 0;

    int total = 0;
    int bad = 0;
    int mv_seen = 0;

    // Reference: edges of the (optionally filtered) input stream, scheduled outputs with fixed latency.
    always @(posedge clk) begin
        ev_t e;
        bit  x, all_same;
        cyc++;
        exp_mv = 1'b0;
        if (rst_s_p) begin
            evq.delete();
            hist.delete();
            armed = 0; prev = 0; flvl = 0;
            exp_to = 0; exp_sl = 0; exp_hc = 0; exp_pc = 0;
        end else begin
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                e = evq.pop_front();
                if (e.is_to) begin
                    exp_to = 1'b1;
                    exp_sl = e.lvl;
                end else begin
                    exp_mv = 1'b1;
                    exp_hc = e.h;
                    exp_pc = e.p;
                    exp_to = 1'b0;
                end
            end
            if (FILT) begin
                hist.push_back(pwm_in);
                if (hist.size() > FC) void'(hist.pop_front());
                all_same = (hist.size() == FC);
                foreach (hist[i]) if (hist[i] != pwm_in) all_same = 0;
                if (all_same) flvl = pwm_in;
                x = flvl;
            end else begin
                x = pwm_in;
            end
            if (x && !prev) begin
                if (armed) begin
                    e.due = cyc + LAT_M; e.is_to = 0;
                    e.p = cyc - last_rise; e.h = last_fall - last_rise; e.lvl = 0;
                    evq.push_back(e);
                end
                armed = 1;
                last_rise = cyc;
            end else begin
                if (!x && prev) last_fall = cyc;
                if (armed && (cyc - last_rise == T)) begin
                    e.due = cyc + LAT_M - 1; e.is_to = 1; e.p = 0; e.h = 0; e.lvl = x;
                    evq.push_back(e);
                    armed = 0;
                end
            end
            prev = x;
        end
    end

    task automatic check(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic chk();
        check("meas_valid", {31'd0, meas_valid}, {31'd0, exp_mv});
        check("high_count", high_count, exp_hc);
        check("period_count", period_count, exp_pc);
        check("timeout", {31'd0, timeout}, {31'd0, exp_to});
        check("stuck_level", {31'd0, stuck_level}, {31'd0, exp_sl});
        if (meas_valid === 1'b1) mv_seen++;
    endtask

    task automatic step(input logic v);
        @(negedge clk);
        chk();
        pwm_in = v;
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) step(v);
    endtask

    task automatic period(input int p, input int h);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, p, h;
        rst_s_p = 1'b1;
        pwm_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hc", high_count, 0);
        check("rst_pc", period_count, 0);
        check("rst_mv", {31'd0, meas_valid}, 0);
        check("rst_to", {31'd0, timeout}, 0);
        rst_s_p = 1'b0;
        hold(1'b0, 3);

        repeat (3) period(100, 25);
        check("p1_mv_count", mv_seen, 2);
        check("p1_hc", high_count, 25);
        check("p1_pc", period_count, 100);
        check("p1_to", {31'd0, timeout}, 0);

        hold(1'b1, 600);
        check("hi_stuck_to", {31'd0, timeout}, 1);
        check("hi_stuck_lvl", {31'd0, stuck_level}, 1);
        check("hi_stuck_hc", high_count, 25);
        check("hi_stuck_pc", period_count, 100);

        hold(1'b0, 20);
        repeat (2) period(100, 25);
        check("resume_to", {31'd0, timeout}, 0);

        repeat (3) period(100, 60);
        check("h60_hc", high_count, 60);
        check("h60_pc", period_count, 100);

        hold(1'b0, 600);
        check("lo_stuck_to", {31'd0, timeout}, 1);
        check("lo_stuck_lvl", {31'd0, stuck_level}, 0);
        check("lo_stuck_pc", period_count, 100);

        repeat (2) period(100, 25);
        hold(1'b1, 10);
        @(negedge clk);
        chk();
        rst_s_p = 1'b1;
        @(negedge clk);
        chk();
        rst_s_p = 1'b0;
        check("midrst_hc", high_count, 0);
        check("midrst_pc", period_count, 0);
        check("midrst_to", {31'd0, timeout}, 0);
        snap = mv_seen;
        hold(1'b1, 15);
        hold(1'b0, 75);
        check("midrst_no_mv", mv_seen, snap);
        repeat (2) period(100, 25);

        repeat (3) period(50, 1);
        repeat (2) period(500, 100);
        hold(1'b1, 10);
        check("exact_T_pc", period_count, 500);
        check("exact_T_to", {31'd0, timeout}, 0);
        hold(1'b0, 40);

        repeat (12) begin
            p = $urandom_range(200, 20);
            h = $urandom_range(p - 8, 8);
            period(p, h);
        end

        repeat (3) begin
            hold(1'b1, 10);
            hold(1'b0, 2);
            hold(1'b1, 13);
            hold(1'b0, 75);
        end
        hold(1'b1, 10);
        check("glitch_hc", high_count, FILT ? 25 : 13);
        check("glitch_pc", period_count, FILT ? 100 : 88);
        hold(1'b0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
